stream_program_loader: RTL

//   Byte-stream program loader feeding the system memory-write path (addr/data/write + load_complete).

---
 rtl/stream_program_loader.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/stream_program_loader.sv
// Length-prefixed byte-stream loader: assembles big-endian words and writes them to RAM from address 0.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module stream_program_loader #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start_load,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]     mem_write_data,
    output logic                     mem_write,
    output logic                     load_complete,
    output logic                     load_error,
    output logic                     busy
);

    localparam int B      = WORD_SIZE / 8;
    localparam int BCNT_W = (B > 1) ? $clog2(B) : 1;
    localparam int IDX_W  = MEM_ADDR_SIZE + 1;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(B - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [16:0]       MAX_WORDS = 17'd1 << MEM_ADDR_SIZE;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6,
        S_CHK    = 3'd7
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_LAST = S_CHK;
`else
    localparam state_t S_LAST = S_DONE;
`endif

    state_t                     state_q, state_d;
    logic [15:0]                count_q, count_d;
    logic [IDX_W-1:0]           index_q, index_d;
    logic [BCNT_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic [WORD_SIZE-1:0]       shift_q, shift_d;
    logic [MEM_ADDR_SIZE-1:0]   mem_addr_q, addr_d;
    logic [WORD_SIZE-1:0]       wdata_q, wdata_d;
    logic                       in_ready_q, ready_d;
    logic                       mem_write_q;
    logic                       load_complete_q;
    logic                       load_error_q;
    logic                       busy_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                 csum_q, csum_d;
`endif

    logic                       accept_s;
    logic [15:0]                hdr_n_s;
    logic [IDX_W-1:0]           next_idx_s;

    function automatic logic [WORD_SIZE-1:0] shift_in(input logic [WORD_SIZE-1:0] word,
                                                      input logic [7:0]           b);
        logic [WORD_SIZE-1:0] t;
        t      = word << 4'd8;
        t[7:0] = b;
        return t;
    endfunction

    assign accept_s   = in_valid && in_ready_q;
    assign hdr_n_s    = {count_q[15:8], in_data};
    assign next_idx_s = index_q + IDX_ONE;

    // Next-state and datapath computation; dropping start_load overrides everything.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        addr_d     = mem_addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (state_q != S_IDLE && !start_load) begin
            state_d    = S_IDLE;
            byte_cnt_d = '0;
            shift_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_load) begin
                        state_d    = S_HDR_HI;
                        count_d    = '0;
                        index_d    = '0;
                        byte_cnt_d = '0;
                        shift_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = 8'h00;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HDR_HI: begin
                    if (accept_s) begin
                        count_d = {in_data, 8'h00};
                        state_d = S_HDR_LO;
                    end else begin
                        state_d = S_HDR_HI;
                    end
                end
                S_HDR_LO: begin
                    if (accept_s) begin
                        count_d = hdr_n_s;
                        index_d = '0;
                        if (hdr_n_s == 16'h0000) begin
                            state_d = S_LAST;
                        end else if ({1'b0, hdr_n_s} > MAX_WORDS) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_HDR_LO;
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        shift_d = shift_in(shift_q, in_data);
`ifdef LOADER_CHECKSUM_EN
                        csum_d  = csum_q ^ in_data;
`endif
                        if (byte_cnt_q == BCNT_LAST) begin
                            state_d    = S_WRITE;
                            byte_cnt_d = '0;
                            addr_d     = index_q[MEM_ADDR_SIZE-1:0];
                            wdata_d    = shift_in(shift_q, in_data);
                        end else begin
                            byte_cnt_d = byte_cnt_q + BCNT_ONE;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
                // The strobe for this write is already on the output; only advance the index here.
                S_WRITE: begin
                    index_d = next_idx_s;
                    if (17'(next_idx_s) == {1'b0, count_q}) begin
                        state_d = S_LAST;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (accept_s) begin
                        if (in_data == csum_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end else begin
                        state_d = S_CHK;
                    end
`else
                    state_d = S_ERROR;
`endif
                end
                S_DONE:  state_d = S_DONE;
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_IDLE;
            endcase
        end
        ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                  (state_d == S_DATA)   || (state_d == S_CHK);
    end

    // State, datapath and registered-output update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            count_q         <= '0;
            index_q         <= '0;
            byte_cnt_q      <= '0;
            shift_q         <= '0;
            mem_addr_q      <= '0;
            wdata_q         <= '0;
            in_ready_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            load_complete_q <= 1'b0;
            load_error_q    <= 1'b0;
            busy_q          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q          <= 8'h00;
`endif
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            index_q         <= index_d;
            byte_cnt_q      <= byte_cnt_d;
            shift_q         <= shift_d;
            mem_addr_q      <= addr_d;
            wdata_q         <= wdata_d;
            in_ready_q      <= ready_d;
            mem_write_q     <= (state_d == S_WRITE);
            load_complete_q <= (state_d == S_DONE);
            load_error_q    <= (state_d == S_ERROR);
            busy_q          <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
`ifdef LOADER_CHECKSUM_EN
            csum_q          <= csum_d;
`endif
        end
    end

    assign in_ready       = in_ready_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = wdata_q;
    assign mem_write      = mem_write_q;
    assign load_complete  = load_complete_q;
    assign load_error     = load_error_q;
    assign busy           = busy_q;

endmodule
